// File: rtl/regfile_2w2r.sv
// Two-write/two-read register file with optional zero register, write bypass and post-reset init sweep.
// Latency: reads combinational, writes land on the next edge; backpressure: ready stays low during init and writes are dropped.
module regfile_2w2r #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we0,
    input  logic [ADDR_W-1:0] waddr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] waddr1,
    input  logic [DATA_W-1:0] wdata1,
    input  logic [ADDR_W-1:0] raddr0,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              ready
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] CNT_LAST = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic                in_init;
    logic                wr0_ok;
    logic                wr1_ok;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_INIT: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_INIT;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Port 1 wins an address collision, so port 0 is suppressed rather than relying on write order.
    assign in_init = (state_q == ST_INIT);
    assign wr1_ok  = !in_init && we1 && !((ZERO_REG != 0) && (waddr1 == '0));
    assign wr0_ok  = !in_init && we0 && !((ZERO_REG != 0) && (waddr0 == '0))
                     && !(we1 && (waddr1 == waddr0));

    // No array reset: the init sweep clears one entry per cycle so this can map to RAM.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (in_init) begin
                mem_q[cnt_q] <= '0;
            end
            if (wr0_ok) begin
                mem_q[waddr0] <= wdata0;
            end
            if (wr1_ok) begin
                mem_q[waddr1] <= wdata1;
            end
        end
    end

    always_comb begin
        rdata0 = mem_q[raddr0];
        if (in_init) begin
            rdata0 = '0;
        end else if ((ZERO_REG != 0) && (raddr0 == '0)) begin
            rdata0 = '0;
        end else if ((BYPASS != 0) && we1 && (waddr1 == raddr0)) begin
            rdata0 = wdata1;
        end else if ((BYPASS != 0) && we0 && (waddr0 == raddr0)) begin
            rdata0 = wdata0;
        end
    end

    always_comb begin
        rdata1 = mem_q[raddr1];
        if (in_init) begin
            rdata1 = '0;
        end else if ((ZERO_REG != 0) && (raddr1 == '0)) begin
            rdata1 = '0;
        end else if ((BYPASS != 0) && we1 && (waddr1 == raddr1)) begin
            rdata1 = wdata1;
        end else if ((BYPASS != 0) && we0 && (waddr0 == raddr1)) begin
            rdata1 = wdata0;
        end
    end

    assign ready = (state_q == ST_RUN);

endmodule

// File: tb/tb_regfile_2w2r.sv
// Scoreboard bench for regfile_2w2r: a bypassing instance and a non-bypassing twin share all inputs.
module tb_regfile_2w2r;

    logic        clk = 1'b0;
    logic        reset;
    logic        we0, we1;
    logic [4:0]  waddr0, waddr1, raddr0, raddr1;
    logic [31:0] wdata0, wdata1;
    logic [31:0] rdata0, rdata1, nb_rdata0, nb_rdata1;
    logic        ready, nb_ready;

    always #5 clk = ~clk;

    regfile_2w2r #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) dut (
        .clk(clk), .reset(reset),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .raddr0(raddr0), .raddr1(raddr1),
        .rdata0(rdata0), .rdata1(rdata1), .ready(ready)
    );

    regfile_2w2r #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(0)) dut_nb (
        .clk(clk), .reset(reset),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .raddr0(raddr0), .raddr1(raddr1),
        .rdata0(nb_rdata0), .rdata1(nb_rdata1), .ready(nb_ready)
    );

    // Output selectors for scoreboard entries.
    localparam int S_RD0   = 0;
    localparam int S_RD1   = 1;
    localparam int S_RDY   = 2;
    localparam int S_NB0   = 3;
    localparam int S_NB1   = 4;
    localparam int S_NBRDY = 5;

    typedef struct {
        int          sel;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   stim_done = 1'b0;

    task automatic expect_out(input int sel, input logic [31:0] exp, input string name);
        exp_t e;
        e.sel  = sel;
        e.exp  = exp;
        e.name = name;
        q.push_back(e);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_writes();
        we0 = 1'b0; we1 = 1'b0;
        waddr0 = '0; waddr1 = '0;
        wdata0 = '0; wdata1 = '0;
    endtask

    // Monitor: every output sample point, drain what the driver queued for this cycle.
    initial begin
        forever begin
            @(negedge clk);
            while (q.size() > 0) begin
                exp_t e;
                logic [31:0] act;
                e = q.pop_front();
                case (e.sel)
                    S_RD0:   act = rdata0;
                    S_RD1:   act = rdata1;
                    S_RDY:   act = {31'd0, ready};
                    S_NB0:   act = nb_rdata0;
                    S_NB1:   act = nb_rdata1;
                    default: act = {31'd0, nb_ready};
                endcase
                n_cmp++;
                if (act !== e.exp) begin
                    n_bad++;
                    $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", e.name, act, e.exp, $time);
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        idle_writes();
        raddr0 = '0; raddr1 = '0;

        // Two reset cycles with a write request that must be dropped.
        we0 = 1'b1; waddr0 = 5'd4; wdata0 = 32'hCAFE_0004;
        cyc();
        cyc();
        idle_writes();
        expect_out(S_RDY, 32'd0, "reset_ready");
        expect_out(S_NBRDY, 32'd0, "reset_ready_nb");

        // Init sweep: ready low for 32 cycles, reads zero throughout.
        reset = 1'b0;
        for (int i = 0; i < 32; i++) begin
            raddr0 = 5'(i);
            raddr1 = 5'(31 - i);
            expect_out(S_RDY, 32'd0, "init_ready");
            expect_out(S_RD0, 32'd0, "init_rd0");
            expect_out(S_RD1, 32'd0, "init_rd1");
            cyc();
        end

        // First RUN cycle carries a write; bypass instance forwards, the other shows old data.
        expect_out(S_RDY, 32'd1, "ready_rise");
        expect_out(S_NBRDY, 32'd1, "ready_rise_nb");
        we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'hDEAD_BEEF;
        raddr0 = 5'd5; raddr1 = 5'd4;
        expect_out(S_RD0, 32'hDEAD_BEEF, "bypass_w0");
        expect_out(S_NB0, 32'd0, "nobypass_w0");
        expect_out(S_RD1, 32'd0, "reset_write_dropped");
        cyc();
        idle_writes();
        expect_out(S_RD0, 32'hDEAD_BEEF, "stored_w0");
        expect_out(S_NB0, 32'hDEAD_BEEF, "stored_w0_nb");
        cyc();

        // All addresses other than 5 still hold zero after init.
        for (int i = 0; i < 32; i++) begin
            raddr0 = 5'(i);
            raddr1 = 5'(i);
            expect_out(S_RD0, (i == 5) ? 32'hDEAD_BEEF : 32'd0, "post_init_rd0");
            expect_out(S_NB1, (i == 5) ? 32'hDEAD_BEEF : 32'd0, "post_init_rd1_nb");
            cyc();
        end

        // Same-address double write: port 1 wins.
        we0 = 1'b1; waddr0 = 5'd9; wdata0 = 32'h11;
        we1 = 1'b1; waddr1 = 5'd9; wdata1 = 32'h22;
        raddr0 = 5'd9; raddr1 = 5'd9;
        expect_out(S_RD0, 32'h22, "collide_bypass0");
        expect_out(S_RD1, 32'h22, "collide_bypass1");
        expect_out(S_NB0, 32'd0, "collide_nobypass");
        cyc();
        idle_writes();
        expect_out(S_RD0, 32'h22, "collide_stored");
        expect_out(S_NB1, 32'h22, "collide_stored_nb");
        cyc();

        // Distinct-address double write: both stored.
        we0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'hA;
        we1 = 1'b1; waddr1 = 5'd4; wdata1 = 32'hB;
        raddr0 = 5'd3; raddr1 = 5'd4;
        expect_out(S_RD0, 32'hA, "dual_bypass0");
        expect_out(S_RD1, 32'hB, "dual_bypass1");
        expect_out(S_NB1, 32'd0, "dual_nobypass1");
        cyc();
        idle_writes();
        expect_out(S_RD0, 32'hA, "dual_stored0");
        expect_out(S_RD1, 32'hB, "dual_stored1");
        expect_out(S_NB0, 32'hA, "dual_stored0_nb");
        cyc();

        // Writes to the zero register are ignored and never forwarded.
        we1 = 1'b1; waddr1 = 5'd0; wdata1 = 32'hFFFF_FFFF;
        we0 = 1'b1; waddr0 = 5'd0; wdata0 = 32'h5A5A_5A5A;
        raddr0 = 5'd0; raddr1 = 5'd0;
        expect_out(S_RD0, 32'd0, "zero_bypass0");
        expect_out(S_RD1, 32'd0, "zero_bypass1");
        cyc();
        idle_writes();
        expect_out(S_RD0, 32'd0, "zero_after0");
        expect_out(S_NB1, 32'd0, "zero_after1_nb");
        cyc();

        // Store to 7, then reset clears it through the init sweep.
        we0 = 1'b1; waddr0 = 5'd7; wdata0 = 32'h1234;
        cyc();
        idle_writes();
        raddr0 = 5'd7; raddr1 = 5'd2;
        expect_out(S_RD0, 32'h1234, "addr7_stored");
        cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        expect_out(S_RDY, 32'd0, "rerun_ready_low");

        // Ten init edges, then reset again at cnt=10.
        for (int i = 0; i < 10; i++) begin
            expect_out(S_RDY, 32'd0, "partial_init_ready");
            expect_out(S_RD0, 32'd0, "partial_init_rd7");
            cyc();
        end
        reset = 1'b1;
        cyc();
        reset = 1'b0;

        // Full 32-cycle init after the second release; a write mid-init is dropped.
        for (int i = 0; i < 32; i++) begin
            if (i == 20) begin
                we0 = 1'b1; waddr0 = 5'd2; wdata0 = 32'h55;
                expect_out(S_RD1, 32'd0, "init_write_masked");
            end
            expect_out(S_RDY, 32'd0, "restart_ready");
            expect_out(S_RD0, 32'd0, "restart_rd7");
            cyc();
            idle_writes();
        end
        expect_out(S_RDY, 32'd1, "restart_ready_rise");
        expect_out(S_RD0, 32'd0, "addr7_cleared");
        expect_out(S_RD1, 32'd0, "addr2_init_write_dropped");
        expect_out(S_NB0, 32'd0, "addr7_cleared_nb");
        cyc();
        raddr0 = 5'd5;
        expect_out(S_RD0, 32'd0, "addr5_cleared");
        cyc();
        cyc();
        stim_done = 1'b1;
    end

    initial begin
        int budget;
        budget = 0;
        while (!stim_done && budget < 5000) begin
            @(posedge clk);
            budget++;
        end
        if (!stim_done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout: stimulus not finished after %0d cycles, expected completion", budget);
        end
        @(posedge clk);
        if (q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
